imem_arbiter: RTL

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/imem_arbiter.sv
// Instruction memory arbiter: round-robin fetch/debug port sharing with
// idle-driven memory clock gating (ACTIVE -> SLEEP -> WAKE -> ACTIVE).
module imem_arbiter #(
    parameter int unsigned IDLE_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_gnt,
    output logic        fetch_rvalid,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_clk_en
);

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        SLEEP  = 2'd1,
        WAKE   = 2'd2
    } state_t;

    localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] idle_cnt_q;
    logic [7:0] idle_cnt_d;
    logic       last_dbg_q;
    logic       last_dbg_d;

    logic       can_grant;
    logic       any_req;
    logic       rvalid_pend;
    logic       gnt_f;
    logic       gnt_d;

    // Grants are gated by reset so outputs read as idle while reset_n is low.
    assign can_grant   = reset_n && (state_q == ACTIVE);
    assign any_req     = fetch_req | dbg_req;
    assign rvalid_pend = fetch_rvalid | dbg_rvalid;

    always_comb begin
        gnt_f = 1'b0;
        gnt_d = 1'b0;
        if (can_grant) begin
            unique case ({fetch_req, dbg_req})
                2'b11: begin
                    gnt_f = last_dbg_q;
                    gnt_d = ~last_dbg_q;
                end
                2'b10:   gnt_f = 1'b1;
                2'b01:   gnt_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (1'b1)
            gnt_f: begin
                mem_en   = 1'b1;
                mem_addr = fetch_addr;
            end
            gnt_d: begin
                mem_en    = 1'b1;
                mem_we    = dbg_we;
                mem_addr  = dbg_addr;
                mem_wdata = dbg_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        last_dbg_d = last_dbg_q;
        unique case (state_q)
            ACTIVE: begin
                if (gnt_f || gnt_d) begin
                    idle_cnt_d = '0;
                    last_dbg_d = gnt_d;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    state_d    = SLEEP;
                    idle_cnt_d = '0;
                end else if (rvalid_pend) begin
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                end
            end
            SLEEP: begin
                idle_cnt_d = '0;
                if (any_req) begin
                    state_d = WAKE;
                end
            end
            WAKE: begin
                idle_cnt_d = '0;
                state_d    = ACTIVE;
            end
            default: begin
                idle_cnt_d = '0;
                state_d    = ACTIVE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ACTIVE;
            idle_cnt_q   <= '0;
            last_dbg_q   <= 1'b1;
            fetch_rvalid <= 1'b0;
            dbg_rvalid   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idle_cnt_q   <= idle_cnt_d;
            last_dbg_q   <= last_dbg_d;
            fetch_rvalid <= gnt_f;
            dbg_rvalid   <= gnt_d & ~dbg_we;
        end
    end

    assign fetch_gnt  = gnt_f;
    assign dbg_gnt    = gnt_d;
    assign rdata      = mem_rdata;
    assign mem_clk_en = (state_q != SLEEP);

endmodule
